alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu.sv | 27 ++
 rtl/alu_arbiter.sv | 95 +++++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op-codes and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB modulo 2^WIDTH; unknown codes give zero plus an error flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             op_err
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    result = '0;
    op_err = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: op_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, operand latch,
// fixed IDLE -> EXEC -> DONE sequence with a one-cycle ACK to the winner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [3:0]       OP0,
  input  logic [3:0]       OP1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [WIDTH-1:0] RESULT,
  output logic             OP_ERR,
  output logic             BUSY
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             winner_q;
  logic             last_q;
  logic             grant_1;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  // Requester 1 wins when alone, or on a conflict when requester 0 was served last.
  assign grant_1 = REQ1 && (!REQ0 || !last_q);

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .op_err (alu_err)
  );

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RESET_N) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      RESULT   <= '0;
      OP_ERR   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (REQ0 || REQ1) begin
            winner_q <= grant_1;
            a_q      <= grant_1 ? A1  : A0;
            b_q      <= grant_1 ? B1  : B0;
            op_q     <= grant_1 ? OP1 : OP0;
          end
        end
        EXEC: begin
          RESULT <= alu_result;
          OP_ERR <= alu_err;
        end
        DONE:    last_q <= winner_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ACK0    = 1'b0;
    ACK1    = 1'b0;
    BUSY    = (state_q != IDLE);
    case (state_q)
      IDLE: if (REQ0 || REQ1) state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: begin
        ACK0    = !winner_q;
        ACK1    = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus hand-written multi-cycle sequences,
// with ACK-time results checked against a scoreboard queue.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             REQ0 = 1'b0, REQ1 = 1'b0;
  logic [WIDTH-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic [3:0]       OP0 = '0, OP1 = '0;
  logic             ACK0, ACK1, OP_ERR, BUSY;
  logic [WIDTH-1:0] RESULT;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .REQ1(REQ1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .OP0(OP0), .OP1(OP1),
    .ACK0(ACK0), .ACK1(ACK1),
    .RESULT(RESULT), .OP_ERR(OP_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             who;
    logic [WIDTH-1:0] result;
    logic             err;
  } exp_t;

  typedef struct {
    logic             who;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic [WIDTH-1:0] result;
    logic             err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic who, input logic [WIDTH-1:0] res, input logic err);
    exp_t e;
    e.who = who;
    e.result = res;
    e.err = err;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every ACK must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (ACK0 && ACK1) check("ack_exclusive", {31'b0, ACK0 & ACK1}, '0);
      if (ACK0 || ACK1) begin
        if (sb.size() == 0) begin
          check("spurious_ack", {30'b0, ACK1, ACK0}, '0);
        end else begin
          mon_e = sb.pop_front();
          check("ack_who", {31'b0, ACK1}, {31'b0, mon_e.who});
          check("result", RESULT, mon_e.result);
          check("op_err", {31'b0, OP_ERR}, {31'b0, mon_e.err});
        end
      end
    end
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 32'd89,         32'd11,         4'b0010, 32'd100,        1'b0};
    vecs[1] = '{1'b1, 32'd7,          32'd9,          4'b1111, 32'd0,          1'b1};
    vecs[2] = '{1'b1, 32'd0,          32'd1,          4'b0110, 32'hFFFF_FFFF,  1'b0};
    vecs[3] = '{1'b0, 32'hF0F0_1234,  32'h0FF0_FFFF,  4'b0000, 32'h00F0_1234,  1'b0};
    vecs[4] = '{1'b0, 32'hA000_0000,  32'h0000_000B,  4'b0001, 32'hA000_000B,  1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF,  32'd2,          4'b0010, 32'd1,          1'b0};
    vecs[6] = '{1'b0, 32'd123,        32'd456,        4'b0011, 32'd0,          1'b1};
    vecs[7] = '{1'b1, 32'd5,          32'd3,          4'b0110, 32'd2,          1'b0};

    // Reset state
    tick();
    tick();
    check("rst_ack", {30'b0, ACK1, ACK0}, '0);
    check("rst_busy", {31'b0, BUSY}, '0);
    check("rst_result", RESULT, '0);
    check("rst_op_err", {31'b0, OP_ERR}, '0);
    RESET_N = 1'b1;
    tick();

    // Conflict right after reset: requester 0 wins, requester 1 follows three cycles later.
    REQ0 = 1'b1; A0 = 32'd73256; B0 = 32'd897; OP0 = 4'b0110;
    REQ1 = 1'b1; A1 = 32'd1;     B1 = 32'd1;   OP1 = 4'b0000;
    push(1'b0, 32'd72359, 1'b0);
    push(1'b1, 32'd1, 1'b0);
    tick();
    check("conf_exec_ack", {30'b0, ACK1, ACK0}, '0);
    tick();
    check("conf_ack0", {30'b0, ACK1, ACK0}, 32'd1);
    REQ0 = 1'b0;
    tick();
    check("conf_idle_ack", {30'b0, ACK1, ACK0}, '0);
    tick();
    tick();
    check("conf_ack1", {30'b0, ACK1, ACK0}, 32'd2);
    REQ1 = 1'b0;
    tick();

    // Table: single requester, fixed two-cycle latency, result held afterwards.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].who) begin
        REQ1 = 1'b1; A1 = vecs[i].a; B1 = vecs[i].b; OP1 = vecs[i].op;
      end else begin
        REQ0 = 1'b1; A0 = vecs[i].a; B0 = vecs[i].b; OP0 = vecs[i].op;
      end
      push(vecs[i].who, vecs[i].result, vecs[i].err);
      tick();
      check("tbl_busy_exec", {31'b0, BUSY}, 32'd1);
      check("tbl_no_early_ack", {30'b0, ACK1, ACK0}, '0);
      tick();
      check("tbl_ack", {30'b0, ACK1, ACK0}, vecs[i].who ? 32'd2 : 32'd1);
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      tick();
      check("tbl_busy_idle", {31'b0, BUSY}, '0);
      check("tbl_result_hold", RESULT, vecs[i].result);
    end

    // Both requests held: ACKs alternate 0,1,0,1 every third cycle starting from requester 0.
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    REQ0 = 1'b1; A0 = 32'd10; B0 = 32'd3; OP0 = 4'b0010;
    REQ1 = 1'b1; A1 = 32'd10; B1 = 32'd3; OP1 = 4'b0110;
    push(1'b0, 32'd13, 1'b0);
    push(1'b1, 32'd7, 1'b0);
    push(1'b0, 32'd13, 1'b0);
    push(1'b1, 32'd7, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("rr_ack0", {31'b0, ACK0}, {31'b0, (k % 3 == 2) && ((k / 3) % 2 == 0)});
      check("rr_ack1", {31'b0, ACK1}, {31'b0, (k % 3 == 2) && ((k / 3) % 2 == 1)});
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    tick();
    tick();

    // Operand change after latch must not affect the result.
    REQ0 = 1'b1; A0 = 32'd567; B0 = 32'd879; OP0 = 4'b0010;
    push(1'b0, 32'd1446, 1'b0);
    tick();
    A0 = 32'd0;
    tick();
    check("latch_ack0", {30'b0, ACK1, ACK0}, 32'd1);
    REQ0 = 1'b0;
    tick();

    // Reset during EXEC abandons the operation without an ACK.
    REQ1 = 1'b1; A1 = 32'd5; B1 = 32'd5; OP1 = 4'b0010;
    tick();
    check("abort_busy_exec", {31'b0, BUSY}, 32'd1);
    RESET_N = 1'b0;
    tick();
    check("abort_ack", {30'b0, ACK1, ACK0}, '0);
    check("abort_busy", {31'b0, BUSY}, '0);
    REQ1 = 1'b0;
    RESET_N = 1'b1;
    tick();
    tick();
    tick();
    check("abort_no_late_ack", {30'b0, ACK1, ACK0}, '0);
    check("sb_drained", sb.size(), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
